// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-port word memory with a simple request/response handshake for a
//   multi-cycle CPU. A request is accepted in IDLE, the optional WAIT state
//   inserts WAIT_CYCLES busy cycles, and RESPOND pulses mem_ready for one cycle.
//   Storage is DEPTH words of 32 bits and is not cleared by reset.
//
// Parameters
//   DEPTH_LOG2  : log2 of storage depth in 32-bit words (default 8)
//   WAIT_CYCLES : extra busy cycles before each response, 0..15 (default 0)
//
// Ports
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   MemRead    in   1   read request
//   MemWrite   in   1   write request (wins over MemRead when both are high)
//   addr       in  32   byte address, word index addr[DEPTH_LOG2+1:2]
//   wdata      in  32   write data
//   rdata      out 32   read data, updated on read responses and then held
//   mem_ready  out  1   one-cycle completion pulse
//   mem_busy   out  1   high whenever the FSM is not in IDLE
//   mem_err    out  1   misalignment flag, pulses with mem_ready
//
// Configuration
//   MEM_ALIGN_CHECK_EN : when defined, accesses with addr[1:0] != 0 complete
//   normally but pulse mem_err, drop the write and return zero for a read.
//   When undefined, addr[1:0] is ignored and mem_err is tied low.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic [3:0]              w_next_cnt;
  logic                    r_is_write;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic                    r_mem_ready;
  logic                    r_mem_busy;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_accept;
  logic [DEPTH_LOG2-1:0]   w_req_idx;
  logic [DEPTH_LOG2-1:0]   w_rd_idx;
  logic                    w_rd_is_read;
  logic                    w_suppress;
  logic                    w_commit_ok;
  logic                    w_unused_addr;

  assign w_accept  = (r_state == ST_IDLE) && (MemRead || MemWrite);
  assign w_req_idx = addr[DEPTH_LOG2+1:2];

  // With WAIT_CYCLES=0 RESPOND is entered straight from IDLE, so the read
  // index and request type must come from the live inputs on that edge.
  assign w_rd_idx     = (r_state == ST_IDLE) ? w_req_idx : r_idx;
  assign w_rd_is_read = (r_state == ST_IDLE) ? (MemRead && !MemWrite) : !r_is_write;

  // Upper address bits alias; low bits only matter for the alignment check.
  assign w_unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misaligned;
  logic r_mem_err;

  assign w_suppress  = (r_state == ST_IDLE) ? (addr[1:0] != 2'b00) : r_misaligned;
  assign w_commit_ok = !r_misaligned;
  assign mem_err     = r_mem_err;

  // Latch the misalignment of the accepted request and pulse mem_err with ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_misaligned <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_misaligned <= (addr[1:0] != 2'b00);
      end
      r_mem_err <= (w_next_state == ST_RESPOND) && w_suppress;
    end
  end
`else
  assign w_suppress  = 1'b0;
  assign w_commit_ok = 1'b1;
  assign mem_err     = 1'b0;
`endif

  // Next-state and wait-counter logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (LP_WAIT != 4'd0) begin
            w_next_state = ST_WAIT;
            w_next_cnt   = LP_WAIT;
          end else begin
            w_next_state = ST_RESPOND;
            w_next_cnt   = 4'd0;
          end
        end else begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 4'd0;
        end
      end
      ST_WAIT: begin
        // r_cnt holds the WAIT cycles remaining including the current one.
        if (r_cnt <= 4'd1) begin
          w_next_state = ST_RESPOND;
          w_next_cnt   = 4'd0;
        end else begin
          w_next_state = ST_WAIT;
          w_next_cnt   = r_cnt - 4'd1;
        end
      end
      ST_RESPOND: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_is_write  <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
      r_mem_ready <= 1'b0;
      r_mem_busy  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_mem_ready <= (w_next_state == ST_RESPOND);
      r_mem_busy  <= (w_next_state != ST_IDLE);
      if (w_accept) begin
        r_is_write <= MemWrite;
        r_idx      <= w_req_idx;
        r_wdata    <= wdata;
      end
      if ((w_next_state == ST_RESPOND) && w_rd_is_read) begin
        r_rdata <= w_suppress ? 32'd0 : r_mem[w_rd_idx];
      end
    end
  end

  // Storage write port: commits on the edge that ends RESPOND, never under reset.
  always_ff @(posedge clk) begin
    if (reset_n && (r_state == ST_RESPOND) && r_is_write && w_commit_ok) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign rdata     = r_rdata;
  assign mem_ready = r_mem_ready;
  assign mem_busy  = r_mem_busy;

endmodule
